// File: rtl/uart_txser.sv
// Transmit half of the UART: BUFSZ-deep byte FIFO feeding an 8N1 serialiser.
// The bit period is sampled from clockcyclesperbit_i at each frame load.
module uart_txser #(
  parameter int unsigned BUFSZ                  = 2,
  parameter int unsigned CLOCKCYCLESPERBITLIMIT = 1 << 30,
  localparam int unsigned CLOG2BUFSZ            = $clog2(BUFSZ),
  localparam int unsigned CPBW                  = $clog2(CLOCKCYCLESPERBITLIMIT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CPBW-1:0]       clockcyclesperbit_i,
  input  logic                  push_i,
  input  logic [7:0]            data_i,
  output logic                  full_o,
  output logic [CLOG2BUFSZ:0]   usage_o,
  output logic                  busy_o,
  output logic                  tx_o
);

  localparam logic [CLOG2BUFSZ:0] FULL_CNT = (CLOG2BUFSZ + 1)'(BUFSZ);
  localparam logic [CLOG2BUFSZ:0] PTR_ONE  = (CLOG2BUFSZ + 1)'(1);
  localparam logic [CPBW-1:0]     CYC_ONE  = CPBW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic [7:0]          mem [BUFSZ];
  logic [CLOG2BUFSZ:0] wptr;
  logic [CLOG2BUFSZ:0] rptr;
  logic [CLOG2BUFSZ:0] usage;
  logic [7:0]          shift;
  logic [2:0]          bitcnt;
  logic [CPBW-1:0]     period;
  logic [CPBW-1:0]     cyccnt;
  logic [CPBW-1:0]     period_nxt;
  logic                empty;
  logic                do_push;
  logic                do_pop;
  logic                bit_done;

  assign usage      = wptr - rptr;
  assign usage_o    = usage;
  assign full_o     = (usage == FULL_CNT);
  assign empty      = (usage == '0);
  assign do_push    = push_i && !full_o;
  assign bit_done   = (cyccnt == '0);
  assign period_nxt = (clockcyclesperbit_i == '0) ? CYC_ONE : clockcyclesperbit_i;

  // A frame load happens from IDLE or at the final cycle of a stop bit.
  assign do_pop = !empty && ((state == IDLE) || ((state == STOP) && bit_done));

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wptr[CLOG2BUFSZ-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr <= '0;
    end else if (do_push) begin
      wptr <= wptr + PTR_ONE;
    end
  end

  // Frame load is hoisted ahead of the state case; it covers both IDLE and end-of-STOP.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      rptr   <= '0;
      shift  <= '0;
      bitcnt <= '0;
      period <= CYC_ONE;
      cyccnt <= '0;
      tx_o   <= 1'b1;
      busy_o <= 1'b0;
    end else if (do_pop) begin
      rptr   <= rptr + PTR_ONE;
      shift  <= mem[rptr[CLOG2BUFSZ-1:0]];
      period <= period_nxt;
      cyccnt <= period_nxt - CYC_ONE;
      state  <= START;
      tx_o   <= 1'b0;
      busy_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
        START: begin
          if (bit_done) begin
            state  <= DATA;
            tx_o   <= shift[0];
            bitcnt <= '1;
            cyccnt <= period - CYC_ONE;
          end else begin
            cyccnt <= cyccnt - CYC_ONE;
          end
        end
        DATA: begin
          if (bit_done) begin
            cyccnt <= period - CYC_ONE;
            if (bitcnt == '0) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end else begin
              shift  <= shift >> 1;
              tx_o   <= shift[1];
              bitcnt <= bitcnt - 3'd1;
            end
          end else begin
            cyccnt <= cyccnt - CYC_ONE;
          end
        end
        STOP: begin
          if (bit_done) begin
            state  <= IDLE;
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            cyccnt <= cyccnt - CYC_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txser.sv
// Bench for uart_txser: directed pushes queue expected frames; a line monitor
// decodes tx_o cycle by cycle and compares against the queue.
module tb_uart_txser;

  localparam int unsigned CPBW = 30;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [CPBW-1:0] clockcyclesperbit_i;
  logic            push_i;
  logic [7:0]      data_i;
  logic            full_o;
  logic [1:0]      usage_o;
  logic            busy_o;
  logic            tx_o;

  uart_txser #(
    .BUFSZ                 (2),
    .CLOCKCYCLESPERBITLIMIT(1 << 30)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .clockcyclesperbit_i(clockcyclesperbit_i),
    .push_i             (push_i),
    .data_i             (data_i),
    .full_o             (full_o),
    .usage_o            (usage_o),
    .busy_o             (busy_o),
    .tx_o               (tx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  data;
    int unsigned p;
    bit          contig;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   in_frame    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic enq(input logic [7:0] b, input int unsigned p, input bit contig);
    exp_t e;
    e.data = b;
    e.p = p;
    e.contig = contig;
    exp_q.push_back(e);
  endtask

  // Push is accepted on the next edge; returns #1 after that edge.
  task automatic push_byte(input logic [7:0] b, input int unsigned p, input bit en, input bit contig);
    push_i = 1'b1;
    data_i = b;
    if (en) enq(b, p, contig);
    tick(1);
    push_i = 1'b0;
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy_o || in_frame) && n < limit) begin
      tick(1);
      n++;
    end
    if (n >= limit) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d frames still pending after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
    tick(20);
  endtask

  // Line monitor: every frame is compared sample by sample against 10*P expected levels.
  initial begin : monitor
    bit          prev;
    int unsigned cyc;
    int unsigned last_end;
    int unsigned start;
    int unsigned p;
    int unsigned bad_idx;
    logic [9:0]  pat;
    logic [7:0]  got;
    bit          bad;
    bit          aborted;
    exp_t        e;
    prev = 1'b1;
    cyc = 0;
    last_end = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_i) begin
        prev = 1'b1;
        in_frame = 1'b0;
        continue;
      end
      if (prev && !tx_o) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: tx_o fell at cycle %0d, required line idle", cyc);
        end else begin
          e = exp_q.pop_front();
          p = e.p;
          pat = {1'b1, e.data, 1'b0};
          start = cyc;
          bad = 1'b0;
          bad_idx = 0;
          got = '0;
          aborted = 1'b0;
          in_frame = 1'b1;
          if (e.contig) begin
            vectors++;
            if (start != last_end + 1) begin
              miscompares++;
              $display("FAIL gap_%02h: start at cycle %0d, required %0d", e.data, start, last_end + 1);
            end
          end
          for (int unsigned i = 0; i < 10 * p; i++) begin
            if (i != 0) begin
              @(negedge clk_i);
              cyc++;
              if (!rst_i) begin
                aborted = 1'b1;
                break;
              end
            end
            if (tx_o !== pat[i / p] && !bad) begin
              bad = 1'b1;
              bad_idx = i;
            end
            if ((i % p) == (p / 2) && (i / p) >= 1 && (i / p) <= 8) got[(i / p) - 1] = tx_o;
          end
          in_frame = 1'b0;
          if (aborted) begin
            prev = 1'b1;
            continue;
          end
          vectors++;
          if (bad) begin
            miscompares++;
            $display("FAIL frame_%02h: got byte %02h (first bad sample %0d), required byte %02h with %0d-cycle bits",
                     e.data, got, bad_idx, e.data, p);
          end
          last_end = cyc;
        end
      end
      prev = tx_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_i = 1'b0;
    push_i = 1'b0;
    data_i = '0;
    clockcyclesperbit_i = CPBW'(4);
    tick(3);
    chk("rst_tx", tx_o, 1);
    chk("rst_usage", usage_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b1;
    tick(2);

    // Single byte, N=4: start at E1, busy falls at E41.
    push_byte(8'hA5, 4, 1'b1, 1'b0);
    chk("a5_usage_e0", usage_o, 1);
    chk("a5_busy_e0", busy_o, 0);
    chk("a5_tx_e0", tx_o, 1);
    tick(1);
    chk("a5_tx_e1", tx_o, 0);
    chk("a5_busy_e1", busy_o, 1);
    chk("a5_usage_e1", usage_o, 0);
    tick(39);
    chk("a5_busy_e40", busy_o, 1);
    tick(1);
    chk("a5_busy_e41", busy_o, 0);
    drain(500);

    // N=8, three back-to-back pushes, fourth dropped while full.
    clockcyclesperbit_i = CPBW'(8);
    push_i = 1'b1;
    data_i = 8'h11;
    enq(8'h11, 8, 1'b0);
    tick(1);
    chk("burst_usage_e0", usage_o, 1);
    data_i = 8'h22;
    enq(8'h22, 8, 1'b1);
    tick(1);
    chk("burst_usage_e1", usage_o, 1);
    data_i = 8'h33;
    enq(8'h33, 8, 1'b1);
    tick(1);
    chk("burst_usage_e2", usage_o, 2);
    chk("burst_full_e2", full_o, 1);
    data_i = 8'h44;
    tick(1);
    push_i = 1'b0;
    chk("drop_usage", usage_o, 2);
    chk("drop_full", full_o, 1);
    drain(1000);

    // Period change mid-frame applies at the next load.
    clockcyclesperbit_i = CPBW'(4);
    push_byte(8'hC3, 4, 1'b1, 1'b0);
    push_byte(8'h5A, 6, 1'b1, 1'b1);
    tick(17);
    clockcyclesperbit_i = CPBW'(6);
    drain(500);

    // N=0 and N=1 both give 1-cycle bits.
    clockcyclesperbit_i = '0;
    push_byte(8'h00, 1, 1'b1, 1'b0);
    drain(200);
    clockcyclesperbit_i = CPBW'(1);
    push_byte(8'h00, 1, 1'b1, 1'b0);
    push_byte(8'h3C, 1, 1'b1, 1'b1);
    drain(200);

    // Push coinciding with the end-of-stop pop.
    clockcyclesperbit_i = CPBW'(4);
    push_byte(8'h96, 4, 1'b1, 1'b0);
    tick(10);
    push_byte(8'h69, 4, 1'b1, 1'b1);
    tick(29);
    chk("sim_usage_e40", usage_o, 1);
    push_i = 1'b1;
    data_i = 8'hF0;
    enq(8'hF0, 4, 1'b1);
    tick(1);
    push_i = 1'b0;
    chk("sim_usage_e41", usage_o, 1);
    chk("sim_busy_e41", busy_o, 1);
    chk("sim_tx_e41", tx_o, 0);
    drain(1000);

    // Asynchronous reset mid-data discards the frame and the queued byte.
    push_byte(8'h00, 4, 1'b1, 1'b0);
    push_byte(8'h81, 4, 1'b0, 1'b0);
    tick(10);
    chk("pre_reset_tx", tx_o, 0);
    chk("pre_reset_usage", usage_o, 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_tx", tx_o, 1);
    chk("mid_rst_usage", usage_o, 0);
    chk("mid_rst_full", full_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    tick(2);
    rst_i = 1'b1;
    drain(200);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_usage", usage_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
